// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: two-requester round-robin front end for a single AES-128 core.
// Grants one requester at a time, captures its key/plaintext, launches the core,
// returns the ciphertext to the granted requester and wipes all key material
// once the response is accepted.
//
// Optional build macro AES_ARB_TIMEOUT_EN: when defined, an operation stuck in
// WAIT for TIMEOUT cycles is aborted and answered with rsp_err_o=1 and zero data.
// When undefined, WAIT holds until the core answers and rsp_err_o is tied low.
module aes_req_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_i,
  input  logic [1:0][127:0]     req_key_i,
  input  logic [1:0][127:0]     req_data_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            rsp_valid_o,
  input  logic [1:0]            rsp_ready_i,
  output logic [127:0]          rsp_data_o,
  output logic                  rsp_err_o,
  output logic                  core_start_o,
  output logic [127:0]          core_key_o,
  output logic [127:0]          core_data_o,
  input  logic                  core_valid_i,
  input  logic [127:0]          core_data_i,
  output logic                  core_key_clear_o,
  output logic [15:0]           op_count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic           sel_q;      // requester owning the current operation
  logic           last_q;     // requester served most recently
  logic [127:0]   key_q;
  logic [127:0]   data_q;
  logic [127:0]   rsp_q;
  logic [15:0]    op_cnt_q;

  logic           pick;       // round-robin choice for this IDLE cycle
  logic           grant;      // capture request into the operation regs
  logic           rsp_load;   // capture core ciphertext
  logic           accept;     // response taken by the owning requester

`ifdef AES_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]     tmo_cnt_q;
  logic           tmo_hit;
  logic           err_q;
`endif

  // Round-robin pick: a lone requester always wins, a tie goes to the one not last served.
  always_comb begin
    pick = 1'b0;
    case (req_i)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_q;
      default: pick = 1'b0;
    endcase
  end

  // Next-state and output decode; outputs are zero unless the state drives them.
  always_comb begin
    state_d          = state_q;
    gnt_o            = 2'b00;
    rsp_valid_o      = 2'b00;
    rsp_data_o       = '0;
    rsp_err_o        = 1'b0;
    core_start_o     = 1'b0;
    core_key_o       = '0;
    core_data_o      = '0;
    core_key_clear_o = 1'b0;
    grant            = 1'b0;
    rsp_load         = 1'b0;
    accept           = 1'b0;
`ifdef AES_ARB_TIMEOUT_EN
    tmo_hit          = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // The grant is combinational on req_i, so it is masked while reset is
        // asserted to keep every output low during reset.
        if ((|req_i) && rst_n) begin
          gnt_o[pick] = 1'b1;
          grant       = 1'b1;
          state_d     = S_START;
        end
      end
      S_START: begin
        core_start_o = 1'b1;
        core_key_o   = key_q;
        core_data_o  = data_q;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        core_key_o  = key_q;
        core_data_o = data_q;
        if (core_valid_i) begin
          rsp_load = 1'b1;
          state_d  = S_RESP;
        end
`ifdef AES_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = S_RESP;
        end
`endif
      end
      S_RESP: begin
        rsp_valid_o[sel_q] = 1'b1;
        rsp_data_o         = rsp_q;
`ifdef AES_ARB_TIMEOUT_EN
        rsp_err_o          = err_q;
`endif
        // Only the owner's ready matters; the other requester's is ignored.
        if (rsp_ready_i[sel_q]) begin
          accept           = 1'b1;
          core_key_clear_o = 1'b1;
          state_d          = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Operation registers: capture on grant/core result, wipe on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= 1'b0;
      last_q   <= 1'b1;   // requester 0 wins the first tie
      key_q    <= '0;
      data_q   <= '0;
      rsp_q    <= '0;
      op_cnt_q <= '0;
    end else begin
      if (grant) begin
        sel_q  <= pick;
        key_q  <= req_key_i[pick];
        data_q <= req_data_i[pick];
      end
      if (rsp_load) rsp_q <= core_data_i;
`ifdef AES_ARB_TIMEOUT_EN
      if (tmo_hit) rsp_q <= '0;
`endif
      if (accept) begin
        key_q  <= '0;
        data_q <= '0;
        rsp_q  <= '0;
        last_q <= sel_q;
        if (op_cnt_q != 16'hFFFF) op_cnt_q <= op_cnt_q + 16'd1;
      end
    end
  end

`ifdef AES_ARB_TIMEOUT_EN
  // WAIT watchdog: cleared while entering WAIT, counts every WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 tmo_cnt_q <= '0;
    else if (state_q == S_START) tmo_cnt_q <= '0;
    else if (state_q == S_WAIT)  tmo_cnt_q <= tmo_cnt_q + 8'd1;
  end

  // Error flag travels with the response and is wiped on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        err_q <= 1'b0;
    else if (rsp_load) err_q <= 1'b0;
    else if (tmo_hit)  err_q <= 1'b1;
    else if (accept)   err_q <= 1'b0;
  end
`endif

  assign op_count_o = op_cnt_q;

`ifndef SYNTHESIS
  a_tmo_range: assert property (@(posedge clk) (TIMEOUT >= 1) && (TIMEOUT <= 255));
  a_gnt_1hot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_o));
  a_rsp_1hot:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid_o));
  a_start_1c:  assert property (@(posedge clk) disable iff (!rst_n) core_start_o |=> !core_start_o);
  a_clr_1c:    assert property (@(posedge clk) disable iff (!rst_n) core_key_clear_o |=> !core_key_clear_o);
`endif

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Self-checking bench for aes_req_arbiter: acts as both requesters and the AES
// core, and predicts grants, ciphertext, error flag and op count from a
// transaction-level model (round-robin owner, served count).
module tb_aes_req_arbiter;
  localparam int unsigned TMO = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        req_i = '0;
  logic [1:0][127:0] req_key_i = '0;
  logic [1:0][127:0] req_data_i = '0;
  logic [1:0]        gnt_o;
  logic [1:0]        rsp_valid_o;
  logic [1:0]        rsp_ready_i = '0;
  logic [127:0]      rsp_data_o;
  logic              rsp_err_o;
  logic              core_start_o;
  logic [127:0]      core_key_o;
  logic [127:0]      core_data_o;
  logic              core_valid_i = 1'b0;
  logic [127:0]      core_data_i = '0;
  logic              core_key_clear_o;
  logic [15:0]       op_count_o;

  aes_req_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_i(req_i), .req_key_i(req_key_i), .req_data_i(req_data_i),
    .gnt_o(gnt_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .core_start_o(core_start_o), .core_key_o(core_key_o), .core_data_o(core_data_o),
    .core_valid_i(core_valid_i), .core_data_i(core_data_i),
    .core_key_clear_o(core_key_clear_o),
    .op_count_o(op_count_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: who was served last, how many operations completed.
  logic        last_srv = 1'b1;
  int unsigned exp_cnt  = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Arbitration rule: lone requester wins; on a tie the one not last served.
  function automatic logic [1:0] rr_pick(input logic [1:0] r, input logic last);
    if (r == 2'b11) return last ? 2'b01 : 2'b10;
    return r;
  endfunction

  // Behaviour of the stand-in AES core: any deterministic function will do.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d);
    return k ^ {d[63:0], d[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  // One full operation, entered in an IDLE cycle just after a clock edge.
  // lat <  0 : core never answers (timeout / hold behaviour)
  // lat >= 0 : number of silent WAIT cycles before the core result pulse
  task automatic run_op(input logic [1:0] pat, input logic [127:0] k0, input logic [127:0] d0,
                        input logic [127:0] k1, input logic [127:0] d1,
                        input int lat, input int bp, input int gap,
                        input logic use_ct, input logic [127:0] ct_in);
    logic [1:0]   eg;
    logic         s;
    logic [127:0] ek, ed, ct;
    logic         eerr;
    logic         seen;
    for (int i = 0; i < gap; i++) begin
      req_i = 2'b00; core_valid_i = 1'($urandom); core_data_i = rnd128(); rsp_ready_i = 2'($urandom);
      #1;
      chk("idle_gnt", gnt_o, 2'b00);
      chk("idle_stray", rsp_valid_o, 2'b00);
      tick();
    end
    core_valid_i = 1'b0; rsp_ready_i = 2'b00;
    req_i = pat;
    req_key_i[0] = k0; req_data_i[0] = d0;
    req_key_i[1] = k1; req_data_i[1] = d1;
    #1;
    eg = rr_pick(pat, last_srv);
    s  = eg[1];
    ek = s ? k1 : k0;
    ed = s ? d1 : d0;
    chk("op_count", op_count_o, 128'(exp_cnt));
    chk("gnt", gnt_o, eg);
    chk("idle_key", core_key_o, '0);
    chk("idle_clear", core_key_clear_o, 1'b0);
    tick();
    // START: scramble requester inputs to prove the capture, maybe drop req.
    req_i = 2'($urandom); req_key_i[0] = rnd128(); req_key_i[1] = rnd128();
    req_data_i[0] = rnd128(); req_data_i[1] = rnd128();
    #1;
    chk("start", core_start_o, 1'b1);
    chk("start_key", core_key_o, ek);
    chk("start_data", core_data_o, ed);
    chk("start_gnt", gnt_o, 2'b00);
    tick();
    // WAIT
    eerr = 1'b0;
    ct   = use_ct ? ct_in : core_fn(ek, ed);
    if (lat < 0) begin
`ifdef AES_ARB_TIMEOUT_EN
      for (int i = 0; i < int'(TMO); i++) begin
        #1;
        chk("tmo_wait", {rsp_valid_o, core_start_o}, 3'b000);
        chk("tmo_key", core_key_o, ek);
        tick();
      end
      ct   = '0;
      eerr = 1'b1;
`else
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        #1;
        seen = seen | (|rsp_valid_o) | (core_key_o !== ek);
        tick();
      end
      chk("hold_wait", seen, 1'b0);
      core_valid_i = 1'b1; core_data_i = ct;
      tick();
`endif
    end else begin
      for (int i = 0; i < lat; i++) begin
        #1;
        chk("wait_start", core_start_o, 1'b0);
        chk("wait_key", core_key_o, ek);
        chk("wait_rsp", rsp_valid_o, 2'b00);
        tick();
      end
      core_valid_i = 1'b1; core_data_i = ct;
      #1;
      chk("wait_data", core_data_o, ed);
      tick();
    end
    // RESP with back-pressure; stray core pulses and other-ready must be ignored.
    for (int i = 0; i < bp; i++) begin
      core_valid_i = 1'($urandom); core_data_i = rnd128();
      rsp_ready_i = ~eg & 2'($urandom);
      req_i = 2'($urandom);
      #1;
      chk("rsp_valid", rsp_valid_o, eg);
      chk("rsp_data", rsp_data_o, ct);
      chk("rsp_err", rsp_err_o, eerr);
      chk("rsp_clear", core_key_clear_o, 1'b0);
      chk("rsp_gnt", gnt_o, 2'b00);
      chk("rsp_key", core_key_o, '0);
      tick();
    end
    core_valid_i = 1'b0;
    rsp_ready_i = eg | (~eg & 2'($urandom));
    #1;
    chk("acc_valid", rsp_valid_o, eg);
    chk("acc_data", rsp_data_o, ct);
    chk("acc_err", rsp_err_o, eerr);
    chk("acc_clear", core_key_clear_o, 1'b1);
    tick();
    rsp_ready_i = 2'b00; req_i = 2'b00;
    last_srv = s;
    if (exp_cnt != 32'hFFFF) exp_cnt++;
    #1;
    chk("post_clear", core_key_clear_o, 1'b0);
    chk("post_rsp", rsp_data_o, '0);
  endtask

  // Reset asserted while the operation sits in WAIT.
  task automatic reset_mid_wait();
    req_i = 2'b11; req_key_i[0] = rnd128(); req_key_i[1] = rnd128();
    req_data_i[0] = rnd128(); req_data_i[1] = rnd128();
    tick();                    // START
    tick();                    // WAIT
    tick();                    // WAIT
    rst_n = 1'b0;
    #1;
    chk("rst_outs", {gnt_o, rsp_valid_o, rsp_err_o, core_start_o, core_key_clear_o}, '0);
    chk("rst_key", core_key_o, '0);
    chk("rst_data", core_data_o | rsp_data_o, '0);
    chk("rst_cnt", op_count_o, '0);
    core_valid_i = 1'b1; core_data_i = rnd128();
    tick();
    tick();
    core_valid_i = 1'b0;
    rst_n = 1'b1;
    req_i = 2'b00;
    last_srv = 1'b1;
    exp_cnt  = 0;
    #1;
    chk("rst_norsp", rsp_valid_o, 2'b00);
    chk("rst_noclear", core_key_clear_o, 1'b0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with both requesters already asserting.
    req_i = 2'b11;
    req_key_i[0] = rnd128(); req_key_i[1] = rnd128();
    tick(); tick();
    chk("reset_gnt", gnt_o, 2'b00);
    chk("reset_outs", {rsp_valid_o, rsp_err_o, core_start_o, core_key_clear_o}, '0);
    chk("reset_key", core_key_o | core_data_o | rsp_data_o, '0);
    chk("reset_cnt", op_count_o, '0);
    rst_n = 1'b1;

    // Known-answer operation on requester 0.
    run_op(2'b01, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a,
           rnd128(), rnd128(), 9, 1, 0, 1'b1, 128'h3ad77bb40d7a3660a89ecaf32466ef97);

    // Long back-pressure on requester 0.
    run_op(2'b01, rnd128(), rnd128(), rnd128(), rnd128(), 3, 20, 1, 1'b0, '0);

    // Randomized traffic.
    for (int n = 0; n < 30; n++)
      run_op(2'($urandom_range(1, 3)), rnd128(), rnd128(), rnd128(), rnd128(),
             int'($urandom_range(0, 12)), int'($urandom_range(0, 4)),
             int'($urandom_range(0, 2)), 1'b0, '0);

    // Core never answers.
    run_op(2'($urandom_range(1, 3)), rnd128(), rnd128(), rnd128(), rnd128(), -1, 2, 0, 1'b0, '0);

    // Reset in WAIT, then both requesters held: grants must alternate from requester 0.
    reset_mid_wait();
    for (int n = 0; n < 4; n++)
      run_op(2'b11, rnd128(), rnd128(), rnd128(), rnd128(),
             int'($urandom_range(0, 5)), int'($urandom_range(0, 2)), 0, 1'b0, '0);

    // A few more random operations after the reset.
    for (int n = 0; n < 6; n++)
      run_op(2'($urandom_range(1, 3)), rnd128(), rnd128(), rnd128(), rnd128(),
             int'($urandom_range(0, 8)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), 1'b0, '0);

    #1;
    chk("final_cnt", op_count_o, 128'(exp_cnt));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_req_arbiter.md
AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, WAIT-state cycle limit (1..255) before an operation is aborted.
REQ-002 clk  input  1  block clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_i  input  2  per-requester encryption request, level; bit i = requester i.
REQ-005 req_key_i  input  2x128  per-requester AES-128 key.
REQ-006 req_data_i  input  2x128  per-requester plaintext block.
REQ-007 gnt_o  output  2  one-hot, one-cycle grant pulse; key/data are captured in that cycle.
REQ-008 rsp_valid_o  output  2  one-hot response valid, held until accepted.
REQ-009 rsp_ready_i  input  2  per-requester response accept.
REQ-010 rsp_data_o  output  128  ciphertext of the current response.
REQ-011 rsp_err_o  output  1  current response aborted by timeout.
REQ-012 core_start_o  output  1  one-cycle start pulse to the AES core.
REQ-013 core_key_o  output  128  key to the core.
REQ-014 core_data_o  output  128  plaintext to the core.
REQ-015 core_valid_i  input  1  core result valid, one-cycle pulse.
REQ-016 core_data_i  input  128  core ciphertext.
REQ-017 core_key_clear_o  output  1  one-cycle pulse commanding the core to wipe its key state.
REQ-018 op_count_o  output  16  completed-operation count, saturating.

Function
REQ-019 FSM states: IDLE, START, WAIT, RESP; exactly one active.
REQ-020 IDLE, any req_i set: assert gnt_o[sel] for one cycle, capture req_key_i[sel]/req_data_i[sel] into internal regs, store sel, go START.
REQ-021 Selection is round-robin: one requester asserting -> that one; both -> the one not last served.
REQ-022 START: core_start_o=1 for exactly one cycle, go WAIT; gnt-to-start latency is 1 cycle.
REQ-023 core_key_o/core_data_o equal the captured regs in START and WAIT only; zero in all other states.
REQ-024 WAIT, core_valid_i=1: capture core_data_i into the response reg, rsp_err_o=0, go RESP.
REQ-025 RESP: rsp_valid_o[sel]=1 with rsp_data_o/rsp_err_o stable until rsp_ready_i[sel]=1; rsp_data_o=0 outside RESP.
REQ-026 RESP accept cycle: pulse core_key_clear_o, zero the key/data/response regs, record sel as last served, increment op_count_o unless it is 0xFFFF, go IDLE.
REQ-027 rsp_ready_i of the non-selected requester is ignored; core_valid_i outside WAIT is ignored.
REQ-028 req_i deasserted after grant does not cancel the operation; a request held through RESP is granted again only via IDLE arbitration.
REQ-029 Minimum IDLE-to-IDLE period is 4 cycles plus core latency plus response back-pressure.

Reset
REQ-030 rst_n low: state=IDLE, all outputs 0, captured regs 0, op_count_o=0, last-served = requester 1 (requester 0 wins the first tie), timeout counter 0.
REQ-031 Reset mid-operation discards the operation; no response or core_key_clear_o is issued for it.

Configuration
REQ-032 Macro AES_ARB_TIMEOUT_EN defined: an 8-bit counter clears on WAIT entry and increments each WAIT cycle; when it reaches TIMEOUT without core_valid_i, go RESP with rsp_err_o=1, rsp_data_o=0; the abort still pulses core_key_clear_o and increments op_count_o on accept.
REQ-033 Macro undefined: no counter; WAIT holds indefinitely until core_valid_i; rsp_err_o tied 0.

Verification
REQ-034 Req0 key 2b7e151628aed2a6abf7158809cf4f3c, data 6bc1bee22e409f96e93d7e117393172a; core model returns 3ad77bb40d7a3660a89ecaf32466ef97 after 10 cycles -> gnt_o=01, core_start_o one cycle later, rsp_valid_o=01 with that ciphertext, rsp_err_o=0, op_count_o=1.
REQ-035 Both req_i held from reset -> grants alternate 01,10,01,10 over four operations; core_key_o=0 in every IDLE/RESP cycle.
REQ-036 rsp_ready_i[0] held low 20 cycles in RESP -> rsp_valid_o/rsp_data_o stable 20 cycles; core_key_clear_o pulses exactly once, on the accept cycle.
REQ-037 With AES_ARB_TIMEOUT_EN, TIMEOUT=16, core never responds -> RESP entered 16 cycles after WAIT entry with rsp_err_o=1, rsp_data_o=0; without the macro, still in WAIT after 1000 cycles.
REQ-038 rst_n pulsed low during WAIT -> all outputs 0 immediately; no rsp_valid_o; next grant goes to requester 0 when both request.
